// File: rtl/mgt_01_fp_mul_pipe.sv
// rtl/mgt_01_fp_mul_pipe.sv - pipelined IEEE-754 multiplier (DAZ/FTZ, RNE; FP_MUL_RMODE_EN adds rm_i modes)
`timescale 1ns/1ps
module mgt_01_fp_mul_pipe #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 4,
  localparam int FLEN      = 1 + EXP_W + MAN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [FLEN-1:0]  operand_a_i,
  input  logic [FLEN-1:0]  operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
`ifdef FP_MUL_RMODE_EN
  input  logic [2:0]       rm_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [FLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             inexact_o,
  output logic             invalid_op_o
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((2 ** EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic [FLEN-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic [TAG_W-1:0]       tag;
    logic                   sign;
    logic signed [EW2-1:0]  exp_sum;
    logic                   special;
    logic [FLEN-1:0]        spec_res;
    logic                   nv;
`ifdef FP_MUL_RMODE_EN
    logic [2:0]             rm;
`endif
  } side_t;

  logic             w_stall;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_sign, w_za, w_zb, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_snan_a, w_snan_b;
  side_t            w_s1_side;

  assign w_stall  = ~clk_en_i | (valid_o & ~ready_i);
  assign ready_o  = ~w_stall;

  assign w_sign   = operand_a_i[FLEN-1] ^ operand_b_i[FLEN-1];
  assign w_ea     = operand_a_i[FLEN-2 -: EXP_W];
  assign w_eb     = operand_b_i[FLEN-2 -: EXP_W];
  assign w_ma     = operand_a_i[MAN_W-1:0];
  assign w_mb     = operand_b_i[MAN_W-1:0];
  // A zero exponent is zero regardless of the mantissa: subnormals are flushed on input.
  assign w_za     = (w_ea == '0);
  assign w_zb     = (w_eb == '0);
  assign w_inf_a  = (w_ea == '1) & (w_ma == '0);
  assign w_inf_b  = (w_eb == '1) & (w_mb == '0);
  assign w_nan_a  = (w_ea == '1) & (w_ma != '0);
  assign w_nan_b  = (w_eb == '1) & (w_mb != '0);
  assign w_snan_a = w_nan_a & ~w_ma[MAN_W-1];
  assign w_snan_b = w_nan_b & ~w_mb[MAN_W-1];

  always_comb begin
    w_s1_side         = '0;
    w_s1_side.tag     = tag_i;
    w_s1_side.sign    = w_sign;
    w_s1_side.exp_sum = EW2'({2'b00, w_ea}) + EW2'({2'b00, w_eb}) - EW2'(BIAS);
    w_s1_side.special = 1'b1;
    if (w_nan_a | w_nan_b) begin
      w_s1_side.spec_res = QNAN;
      w_s1_side.nv       = w_snan_a | w_snan_b;
    end else if ((w_inf_a & w_zb) | (w_za & w_inf_b)) begin
      w_s1_side.spec_res = QNAN;
      w_s1_side.nv       = 1'b1;
    end else if (w_inf_a | w_inf_b) begin
      w_s1_side.spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_za | w_zb) begin
      w_s1_side.spec_res = {w_sign, {(FLEN-1){1'b0}}};
    end else begin
      w_s1_side.special  = 1'b0;
    end
`ifdef FP_MUL_RMODE_EN
    w_s1_side.rm = rm_i;
`endif
  end

  logic                  r_s1_vld;
  side_t                 r_s1_side;
  logic [MAN_W:0]        r_s1_ma, r_s1_mb;
  logic [MUL_STAGES-1:0] r_p_vld;
  side_t                 r_p_side [MUL_STAGES];
  logic [PW-1:0]         r_p_prod [MUL_STAGES];
  logic                  r_vld, r_of, r_uf, r_nx, r_nv;
  logic [FLEN-1:0]       r_res;
  logic [TAG_W-1:0]      r_tag;

  side_t                 w_side;
  logic [PW-1:0]         w_prod;
  logic                  w_hi, w_g, w_r, w_s, w_inexact, w_inc, w_sat;
  logic [MAN_W-1:0]      w_mant;
  logic [MAN_W:0]        w_mant_r;
  logic signed [EW2-1:0] w_exp_n, w_exp_f;
  logic [FLEN-1:0]       w_res;
  logic                  w_of, w_uf, w_nx, w_nv;

  assign w_side = r_p_side[MUL_STAGES-1];
  assign w_prod = r_p_prod[MUL_STAGES-1];

  always_comb begin
    w_hi = w_prod[PW-1];
    // Product lies in [1,4); when >= 2 the window moves up one bit and the exponent gains one.
    if (w_hi) begin
      w_mant = w_prod[PW-2 -: MAN_W];
      w_g    = w_prod[MAN_W];
      w_r    = w_prod[MAN_W-1];
      w_s    = |w_prod[MAN_W-2:0];
    end else begin
      w_mant = w_prod[PW-3 -: MAN_W];
      w_g    = w_prod[MAN_W-1];
      w_r    = w_prod[MAN_W-2];
      w_s    = |w_prod[MAN_W-3:0];
    end
    w_exp_n   = w_side.exp_sum + EW2'(w_hi);
    w_inexact = w_g | w_r | w_s;
`ifdef FP_MUL_RMODE_EN
    case (w_side.rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = w_side.sign & w_inexact;
      3'b011:  w_inc = ~w_side.sign & w_inexact;
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_r | w_s | w_mant[0]);
    endcase
    w_sat = (w_side.rm == 3'b001) | ((w_side.rm == 3'b010) & ~w_side.sign) |
            ((w_side.rm == 3'b011) & w_side.sign);
`else
    w_inc = w_g & (w_r | w_s | w_mant[0]);
    w_sat = 1'b0;
`endif
    w_mant_r = {1'b0, w_mant} + (MAN_W+1)'(w_inc);
    w_exp_f  = w_exp_n + EW2'(w_mant_r[MAN_W]);

    w_res = '0;
    w_of  = 1'b0;
    w_uf  = 1'b0;
    w_nx  = 1'b0;
    w_nv  = 1'b0;
    if (w_side.special) begin
      w_res = w_side.spec_res;
      w_nv  = w_side.nv;
    end else if (w_exp_f >= EXP_MAX) begin
      w_of  = 1'b1;
      w_nx  = 1'b1;
      w_res = w_sat ? {w_side.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                    : {w_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_exp_f <= EXP_ZERO) begin
      w_uf  = 1'b1;
      w_nx  = 1'b1;
      w_res = {w_side.sign, {(FLEN-1){1'b0}}};
    end else begin
      w_nx  = w_inexact;
      w_res = {w_side.sign, w_exp_f[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_side <= '0;
      r_s1_ma   <= '0;
      r_s1_mb   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_p_vld[i]  <= 1'b0;
        r_p_side[i] <= '0;
        r_p_prod[i] <= '0;
      end
      r_vld <= 1'b0;
      r_res <= '0;
      r_tag <= '0;
      r_of  <= 1'b0;
      r_uf  <= 1'b0;
      r_nx  <= 1'b0;
      r_nv  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_vld    <= valid_i;
      r_s1_side   <= w_s1_side;
      r_s1_ma     <= {1'b1, w_ma};
      r_s1_mb     <= {1'b1, w_mb};
      r_p_vld[0]  <= r_s1_vld;
      r_p_side[0] <= r_s1_side;
      r_p_prod[0] <= PW'(r_s1_ma) * PW'(r_s1_mb);
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_p_vld[i]  <= r_p_vld[i-1];
        r_p_side[i] <= r_p_side[i-1];
        r_p_prod[i] <= r_p_prod[i-1];
      end
      r_vld <= r_p_vld[MUL_STAGES-1];
      if (r_p_vld[MUL_STAGES-1]) begin
        r_res <= w_res;
        r_tag <= w_side.tag;
        r_of  <= w_of;
        r_uf  <= w_uf;
        r_nx  <= w_nx;
        r_nv  <= w_nv;
      end
    end
  end

  assign valid_o      = r_vld;
  assign result_o     = r_res;
  assign tag_o        = r_tag;
  assign overflow_o   = r_of;
  assign underflow_o  = r_uf;
  assign inexact_o    = r_nx;
  assign invalid_op_o = r_nv;

endmodule

// File: tb/tb_mgt_01_fp_mul_pipe.sv
// tb/tb_mgt_01_fp_mul_pipe.sv - self-checking bench for mgt_01_fp_mul_pipe (vectors, random scoreboard, stall/reset)
`timescale 1ns/1ps
module tb_mgt_01_fp_mul_pipe;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rst_i, clk_en_i, valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] operand_a_i, operand_b_i, result_o;
  logic [3:0]  tag_i, tag_o;
  logic [2:0]  rm_i;
  logic        overflow_o, underflow_o, inexact_o, invalid_op_o;

  always #5 clk = ~clk;

  mgt_01_fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .MUL_STAGES(MS), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .valid_i(valid_i), .ready_o(ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .tag_i(tag_i),
`ifdef FP_MUL_RMODE_EN
    .rm_i(rm_i),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o),
    .invalid_op_o(invalid_op_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                              input logic [31:0] res, input logic [3:0] flg);
    vec_t v;
    v.a = a; v.b = b; v.rm = rm; v.res = res; v.flg = flg;
    return v;
  endfunction

  // Exact integer product, rounded by comparing the discarded remainder with one half ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, kept, rem, half;
    bit s, za, zb, ia, ib, na, nb, sna, snb, up, nx, sat;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    sna = na && !a[22]; snb = nb && !b[22];
    if (na || nb) return {32'h7FC00000, 3'b000, sna | snb};
    if ((ia && zb) || (za && ib)) return {32'h7FC00000, 4'b0001};
    if (ia || ib) return {s, 31'h7F800000, 4'b0000};
    if (za || zb) return {s, 31'h0, 4'b0000};
    p  = ((64'd1 << 23) | fa) * ((64'd1 << 23) | fb);
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && nx;
      3'd3:    up = !s && nx;
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && kept[0]);
    endcase
    kept = kept + 64'(up);
    if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; e++; end
    if (e >= 255) begin
      sat = (rm == 3'd1) || ((rm == 3'd2) && !s) || ((rm == 3'd3) && s);
      return {s, sat ? 31'h7F7FFFFF : 31'h7F800000, 4'b1010};
    end
    if (e <= 0) return {s, 31'h0, 4'b0110};
    return {s, 8'(e), kept[22:0], 2'b00, nx, 1'b0};
  endfunction

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0]  e;
    logic [22:0] m;
    r = $urandom_range(0, 15);
    m = 23'($urandom);
    case (r)
      0:       e = 8'd0;
      1:       begin e = 8'd255; if ($urandom_range(0, 1) == 0) m = '0; end
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  function automatic logic [3:0] flags_now();
    return {overflow_o, underflow_o, inexact_o, invalid_op_o};
  endfunction

  task automatic run_vec(input vec_t v, input logic [3:0] tag, input int idx);
    int n;
    bit got;
    @(negedge clk);
    valid_i = 1'b1; operand_a_i = v.a; operand_b_i = v.b; tag_i = tag; rm_i = v.rm;
    ready_i = 1'b1; clk_en_i = 1'b1;
    @(posedge clk);
    n = 1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      if (valid_o) got = 1'b1;
      else begin @(posedge clk); n++; end
    end
    check($sformatf("vec%0d_latency", idx), got ? n : -1, MS + 2);
    check($sformatf("vec%0d_result", idx), result_o, v.res);
    check($sformatf("vec%0d_flags", idx), flags_now(), v.flg);
    check($sformatf("vec%0d_tag", idx), tag_o, tag);
    @(posedge clk);
  endtask

  vec_t tbl[$];
  logic [39:0] exp_q[$];

  initial begin
    int next_tag, exp_tag, leaks;
    logic [35:0] m;
    logic [39:0] front;

    rst_i = 1'b1; clk_en_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0; tag_i = '0; rm_i = 3'd0;

    tbl.push_back(mk(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000));
    tbl.push_back(mk(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 4'b0001));
    tbl.push_back(mk(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b0001));
    tbl.push_back(mk(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b0000));
    tbl.push_back(mk(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 4'b1010));
    tbl.push_back(mk(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 4'b0110));
    tbl.push_back(mk(32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 4'b0110));
    tbl.push_back(mk(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 4'b0010));
    tbl.push_back(mk(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 4'b0000));
    tbl.push_back(mk(32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 4'b0000));
    tbl.push_back(mk(32'h00400000, 32'h7F800000, 3'd0, 32'h7FC00000, 4'b0001));
    tbl.push_back(mk(32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 4'b0010));
    tbl.push_back(mk(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 4'b0010));
    tbl.push_back(mk(32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 4'b0010));
`ifdef FP_MUL_RMODE_EN
    tbl.push_back(mk(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 4'b1010));
    tbl.push_back(mk(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 4'b0010));
    tbl.push_back(mk(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 4'b1010));
    tbl.push_back(mk(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 4'b0010));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_flags", flags_now(), 0);
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready_after", ready_o, 1);

    foreach (tbl[i]) run_vec(tbl[i], 4'(i + 3), i);

    // Randomised stream with back-pressure and clock-enable gaps against the reference model.
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      clk_en_i    = ($urandom_range(0, 9) != 0);
      ready_i     = clk_en_i && ($urandom_range(0, 3) != 0);
      valid_i     = (c < 400) && ($urandom_range(0, 3) != 0);
      operand_a_i = rand_fp();
      operand_b_i = rand_fp();
      tag_i       = 4'($urandom);
`ifdef FP_MUL_RMODE_EN
      rm_i        = 3'($urandom_range(0, 7));
`else
      rm_i        = 3'd0;
`endif
      #1;
      if (valid_o && ready_i && clk_en_i) begin
        if (exp_q.size() == 0) check("rnd_unexpected_output", {result_o, flags_now(), tag_o}, 40'hx);
        else begin
          front = exp_q.pop_front();
          check("rnd_output", {result_o, flags_now(), tag_o}, front);
        end
      end
      if (valid_i && ready_o) begin
        m = ref_mul(operand_a_i, operand_b_i, rm_i);
        exp_q.push_back({m, tag_i});
      end
    end
    valid_i = 1'b0;
    check("rnd_all_drained", exp_q.size(), 0);
    clk_en_i = 1'b1; ready_i = 1'b1;
    repeat (8) @(posedge clk);

    // Fill the pipe against a blocked consumer, then release it.
    next_tag = 0; exp_tag = 0;
    operand_a_i = 32'h3FC00000; operand_b_i = 32'h40000000; rm_i = 3'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ready_i = (c >= 10);
      valid_i = (next_tag < 6);
      tag_i   = 4'(next_tag);
      #1;
      if (c == 9) begin
        check("seq_ready_dropped", ready_o, 0);
        check("seq_accepted_when_full", next_tag, MS + 2);
        check("seq_held_tag", tag_o, 0);
        check("seq_held_result", result_o, 32'h40400000);
      end
      if (valid_o && ready_i) begin
        check("seq_tag_order", tag_o, exp_tag);
        exp_tag++;
      end
      if (valid_i && ready_o) next_tag++;
    end
    valid_i = 1'b0;
    check("seq_result_count", exp_tag, 6);

    // Reset with operations in flight: none of them may surface.
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid_i = 1'b1; tag_i = 4'(c + 8);
    end
    @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_valid_low", valid_o, 0);
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_ready", ready_o, 1);
    leaks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (valid_o) leaks++;
    end
    check("midrst_no_leak", leaks, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
